// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file:
// clear-engine state encoding and the byte-enable merge used by writes and bypass.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    // merge_be works on a fixed container; callers cast their WIDTH (<= 512) in and out.
    localparam int MERGE_MAX_W  = 512;
    localparam int MERGE_MAX_BW = MERGE_MAX_W / 8;

    function automatic logic [MERGE_MAX_W-1:0] merge_be(
        input logic [MERGE_MAX_W-1:0]  old_val,
        input logic [MERGE_MAX_W-1:0]  new_val,
        input logic [MERGE_MAX_BW-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        for (int k = 0; k < MERGE_MAX_BW; k++) begin
            res[8*k +: 8] = be[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: walks indices 0..DEPTH-1, one per cycle, then pulses done.
// busy, done and the clear-write strobe are all registered.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 23,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    clr_state_e    state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            clr_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                        clr_we   <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Explicit terminal compare keeps non-power-of-two depths from wrapping.
                    if (cnt == LAST_IDX) begin
                        state    <= DONE;
                        cnt      <= '0;
                        clr_we   <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                    clr_we   <= 1'b0;
                end
            endcase
        end
    end

    assign clr_idx = cnt;

endmodule

// File: rtl/regfile_param_rw.sv
// Parametrised register file: byte-enabled addressed write, two combinational
// read ports with optional same-cycle bypass, and a sequenced bulk clear.
module regfile_param_rw
    import regfile_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter int               DEPTH     = 23,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               BYPASS    = 1,
    localparam int              AW        = $clog2(DEPTH),
    localparam int              BW        = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [BW-1:0]    wr_be,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_drop,
    input  logic [AW-1:0]    rd_addr0,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data0,
    output logic [WIDTH-1:0] rd_data1,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             clr_we;
    logic [AW-1:0]    clr_idx;
    logic             wr_in_range;
    logic             wr_acc;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;

    regfile_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    // A write lands only while idle and not colliding with a clear being accepted.
    assign wr_in_range = int'(wr_addr) < DEPTH;
    assign wr_acc      = we && wr_in_range && !clr_busy && !clr_req;
    assign wr_old      = wr_in_range ? mem[wr_addr] : '0;
    assign wr_merged   = WIDTH'(merge_be(MERGE_MAX_W'(wr_old), MERGE_MAX_W'(wr_data),
                                         MERGE_MAX_BW'(wr_be)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
            wr_drop <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_we && clr_idx == AW'(i)) begin
                    mem[i] <= RESET_VAL;
                end else if (wr_acc && wr_addr == AW'(i)) begin
                    mem[i] <= wr_merged;
                end
            end
            wr_drop <= we && !wr_acc;
        end
    end

    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rd_data [2];

    assign rd_addr[0] = rd_addr0;
    assign rd_addr[1] = rd_addr1;
    assign rd_data0   = rd_data[0];
    assign rd_data1   = rd_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rd_data[p] = '0;
            if (int'(rd_addr[p]) < DEPTH) begin
                if ((BYPASS != 0) && wr_acc && (rd_addr[p] == wr_addr)) begin
                    rd_data[p] = wr_merged;
                end else begin
                    rd_data[p] = mem[rd_addr[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_param_rw.sv
// Directed bench for regfile_param_rw at its default parameters (64 x 23, bypass on).
module tb_regfile_param_rw;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_be;
    logic [63:0]   wr_data;
    logic          wr_drop;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [63:0]   rd_data0;
    logic [63:0]   rd_data1;
    logic          clr_req;
    logic          clr_busy;
    logic          clr_done;

    int checks = 0;
    int errors = 0;

    regfile_param_rw dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .wr_drop  (wr_drop),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
        we      = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [63:0] exp);
        rd_addr0 = a;
        rd_addr1 = a;
        #1;
        chk({tag, "_p0"}, rd_data0, exp);
        chk({tag, "_p1"}, rd_data1, exp);
    endtask

    function automatic logic [63:0] fill(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i) + 64'd1;
    endfunction

    initial begin
        int busy_cnt;
        int done_cnt;

        reset_n  = 1'b0;
        we       = 1'b0;
        wr_addr  = '0;
        wr_be    = '0;
        wr_data  = '0;
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd22;
        clr_req  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd0", rd_data0, 64'h0);
        chk("rst_rd1", rd_data1, 64'h0);
        chk("rst_busy", {63'b0, clr_busy}, 64'h0);
        chk("rst_done", {63'b0, clr_done}, 64'h0);
        chk("rst_drop", {63'b0, wr_drop}, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Same-cycle bypass then persistence
        rd_addr0 = 5'd5;
        we = 1'b1; wr_addr = 5'd5; wr_data = 64'h1122334455667788; wr_be = 8'hFF;
        #1;
        chk("bypass_same_cycle", rd_data0, 64'h1122334455667788);
        @(negedge clk);
        we = 1'b0;
        rd_chk("wr5_next", 5'd5, 64'h1122334455667788);
        @(negedge clk);
        rd_chk("wr5_later", 5'd5, 64'h1122334455667788);

        // Byte-enable merge, including bypass of a partial write
        wr(5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        rd_addr0 = 5'd3;
        we = 1'b1; wr_addr = 5'd3; wr_data = 64'h0; wr_be = 8'h0F;
        #1;
        chk("bypass_merge", rd_data0, 64'hFFFF_FFFF_0000_0000);
        @(negedge clk);
        we = 1'b0;
        chk("merge_nodrop", {63'b0, wr_drop}, 64'h0);
        rd_chk("merge", 5'd3, 64'hFFFF_FFFF_0000_0000);

        // we with no byte enables: no change, no drop
        wr(5'd5, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
        chk("be0_nodrop", {63'b0, wr_drop}, 64'h0);
        rd_chk("be0_nochange", 5'd5, 64'h1122334455667788);

        // Out-of-range write is dropped
        wr(5'd23, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        chk("oor_drop", {63'b0, wr_drop}, 64'h1);
        rd_chk("oor_rd30", 5'd30, 64'h0);
        rd_chk("oor_rd23", 5'd23, 64'h0);
        rd_chk("oor_reg5", 5'd5, 64'h1122334455667788);
        @(negedge clk);
        chk("oor_drop_pulse", {63'b0, wr_drop}, 64'h0);

        // Bulk clear over a full bank
        for (int i = 0; i < 23; i++) wr(AW'(i), fill(i), 8'hFF);
        rd_chk("fill22", 5'd22, fill(22));
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                rd_addr0 = 5'd0;
                rd_addr1 = 5'd22;
                #1;
                chk("mid_reg0", rd_data0, 64'h0);
                chk("mid_reg22", rd_data1, fill(22));
                we = 1'b1; wr_addr = 5'd22; wr_data = 64'h5555; wr_be = 8'hFF;
            end
            if (k == 4) begin
                we = 1'b0;
                chk("busy_drop", {63'b0, wr_drop}, 64'h1);
                #1;
                chk("busy_wr_ignored", rd_data1, fill(22));
            end
            if (k == 24) chk("done_at_24", {63'b0, clr_done}, 64'h1);
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (!clr_busy) break;
            @(negedge clk);
        end
        chk("clr_busy_cycles", 64'(busy_cnt), 64'd24);
        chk("clr_done_pulses", 64'(done_cnt), 64'd1);
        rd_chk("cleared0", 5'd0, 64'h0);
        rd_chk("cleared11", 5'd11, 64'h0);
        rd_chk("cleared22", 5'd22, 64'h0);

        // clr_req and we together in IDLE: clear wins
        rd_addr0 = 5'd4;
        clr_req = 1'b1;
        we = 1'b1; wr_addr = 5'd4; wr_data = 64'hABCD; wr_be = 8'hFF;
        #1;
        chk("collide_no_bypass", rd_data0, 64'h0);
        @(negedge clk);
        clr_req = 1'b0;
        we = 1'b0;
        chk("collide_drop", {63'b0, wr_drop}, 64'h1);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (!clr_busy) break;
            @(negedge clk);
        end
        chk("collide_busy_cycles", 64'(busy_cnt), 64'd24);
        chk("collide_done", 64'(done_cnt), 64'd1);
        rd_chk("collide_reg4", 5'd4, 64'h0);

        // Reset asserted in the middle of a clear
        wr(5'd20, 64'h2, 8'hFF);
        wr(5'd0, 64'h1, 8'hFF);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd20;
        #1;
        chk("pre_rst_reg0", rd_data0, 64'h0);
        chk("pre_rst_reg20", rd_data1, 64'h2);
        chk("pre_rst_busy", {63'b0, clr_busy}, 64'h1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {63'b0, clr_busy}, 64'h0);
        chk("midrst_done", {63'b0, clr_done}, 64'h0);
        chk("midrst_reg20", rd_data1, 64'h0);
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (clr_done) done_cnt++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (clr_done) done_cnt++;
        end
        chk("midrst_no_done", 64'(done_cnt), 64'd0);

        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (!clr_busy) break;
            @(negedge clk);
        end
        chk("post_rst_busy_cycles", 64'(busy_cnt), 64'd24);
        chk("post_rst_done", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
